// File: rtl/fta_bus_pkg.sv
// FTA 64-bit command bus types shared by all bus-attached peripherals.
package fta_bus_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'd0,
    FIXED   = 3'd1,
    INCR    = 3'd2,
    ERC     = 3'd7
  } fta_cycle_type_t;

  typedef logic [3:0]  fta_cid_t;
  typedef logic [12:0] fta_tid_t;
  typedef logic [31:0] fta_address_t;

  typedef struct packed {
    fta_cid_t        cid;
    fta_tid_t        tid;
    logic            we;
    fta_cycle_type_t cti;
    logic [7:0]      sel;
    fta_address_t    padr;
    logic [63:0]     dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    fta_cid_t     cid;
    fta_tid_t     tid;
    logic [3:0]   pri;
    logic         ack;
    logic         err;
    logic         rty;
    fta_address_t adr;
    logic [63:0]  dat;
  } fta_cmd_response64_t;

endpackage

// File: rtl/ledport_pwm_fta64_pkg.sv
// Register map for the LED port PWM peripheral.
package ledport_pwm_fta64_pkg;

  localparam logic [2:0] REG_LEDEN  = 3'd0;
  localparam logic [2:0] REG_MODE   = 3'd1;
  localparam logic [2:0] REG_BLINK  = 3'd2;
  localparam logic [2:0] REG_BRIGHT = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  function automatic logic reg_mapped(input logic [2:0] r);
    return r <= REG_STATUS;
  endfunction

endpackage

// File: rtl/ledport_pwm_fta64_chan.sv
// One LED channel: gates enable, blink phase and PWM duty into a registered drive bit.
module ledport_pwm_chan (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       mode_i,
  input  logic [7:0] duty_i,
  input  logic       phase_i,
  input  logic [7:0] cnt_i,
  output logic       led_o
);

  logic led_q, led_d;

  // Duty 0xFF means fully on; otherwise lit while the count is below the duty.
  always_comb begin
    led_d = en_i & (mode_i ? phase_i : 1'b1) & ((duty_i == 8'hFF) | (cnt_i < duty_i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_q <= 1'b0;
    else      led_q <= led_d;
  end

  assign led_o = led_q;

endmodule

// File: rtl/ledport_pwm_fta64.sv
// LED port with per-channel enable, blink and 8-bit PWM brightness on the FTA64 bus.
module ledport_pwm_fta64
  import fta_bus_pkg::*;
  import ledport_pwm_fta64_pkg::*;
#(
  parameter int          NLED      = 8,
  parameter int          PWM_DIV   = 16,
  parameter logic [31:0] BLINK_RST = 32'd25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  fta_cmd_request64_t  req,
  output fta_cmd_response64_t resp,
  output logic [NLED-1:0]     led
);

  localparam logic [15:0] PRESC_MAX = 16'(PWM_DIV - 1);

  logic [NLED-1:0]       leden_q, leden_d, mode_q, mode_d;
  logic [NLED-1:0][7:0]  bright_q, bright_d;
  logic [31:0]           blink_q, blink_d, bcnt_q, bcnt_d, blink_lim;
  logic [15:0]           presc_q, presc_d;
  logic [7:0]            pwm_q, pwm_d;
  logic                  phase_q, phase_d;
  fta_cmd_response64_t   resp_q, resp_d;
  logic [2:0]            sel;
  logic                  wr, rd, mapped;
  logic [63:0]           rdata;
  logic                  unused_ok;

  assign sel    = req.padr[5:3];
  assign wr     = cs & req.we;
  assign rd     = cs & ~req.we;
  assign mapped = reg_mapped(sel);
  assign unused_ok = ^{req.sel, req.padr[31:6], req.padr[2:0], req.dat};

  always_comb begin
    leden_d  = leden_q;
    mode_d   = mode_q;
    bright_d = bright_q;
    blink_d  = blink_q;
    presc_d  = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
    pwm_d    = (presc_q == PRESC_MAX) ? pwm_q + 8'd1 : pwm_q;
    // A zero half-period behaves as one; >= keeps a shrunk period from running away.
    blink_lim = (blink_q == 32'd0) ? 32'd0 : blink_q - 32'd1;
    if (bcnt_q >= blink_lim) begin
      bcnt_d  = 32'd0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + 32'd1;
      phase_d = phase_q;
    end
    if (wr) begin
      case (sel)
        REG_LEDEN:  leden_d = req.dat[NLED-1:0];
        REG_MODE:   mode_d  = req.dat[NLED-1:0];
        REG_BLINK: begin
          blink_d = req.dat[31:0];
          bcnt_d  = 32'd0;
          phase_d = phase_q;
        end
        REG_BRIGHT: for (int i = 0; i < NLED; i++) bright_d[i] = req.dat[8*i +: 8];
        default: ;
      endcase
    end

    rdata = '0;
    case (sel)
      REG_LEDEN:  rdata[NLED-1:0] = leden_q;
      REG_MODE:   rdata[NLED-1:0] = mode_q;
      REG_BLINK:  rdata[31:0]     = blink_q;
      REG_BRIGHT: for (int i = 0; i < NLED; i++) rdata[8*i +: 8] = bright_q[i];
      REG_STATUS: begin
        rdata[0]    = phase_q;
        rdata[15:8] = pwm_q;
      end
      default: ;
    endcase

    resp_d     = '0;
    resp_d.cid = req.cid;
    resp_d.tid = req.tid;
    resp_d.adr = req.padr;
    resp_d.pri = 4'd7;
    // Unmapped accesses always answer with an error, regardless of cycle type.
    resp_d.ack = cs & (~req.we | (req.cti == ERC) | ~mapped);
    resp_d.err = cs & ~mapped;
    resp_d.dat = (rd & mapped) ? rdata : 64'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leden_q  <= '0;
      mode_q   <= '0;
      bright_q <= '1;
      blink_q  <= BLINK_RST;
      bcnt_q   <= '0;
      presc_q  <= '0;
      pwm_q    <= '0;
      phase_q  <= 1'b0;
      resp_q   <= '0;
    end else begin
      leden_q  <= leden_d;
      mode_q   <= mode_d;
      bright_q <= bright_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      phase_q  <= phase_d;
      resp_q   <= resp_d;
    end
  end

  assign resp = resp_q;

  for (genvar g = 0; g < NLED; g++) begin : g_chan
    ledport_pwm_chan u_chan (
      .clk     (clk),
      .rst     (rst),
      .en_i    (leden_q[g]),
      .mode_i  (mode_q[g]),
      .duty_i  (bright_q[g]),
      .phase_i (phase_q),
      .cnt_i   (pwm_q),
      .led_o   (led[g])
    );
  end

endmodule

// File: tb/tb_ledport_pwm_fta64.sv
// Directed bench for ledport_pwm_fta64: register table, PWM duty, blink timing, reset abort.
module tb_ledport_pwm_fta64;
  import fta_bus_pkg::*;

  localparam int          NLED  = 8;
  localparam logic [31:0] BRST  = 32'd20;

  logic                clk = 1'b0;
  logic                rst;
  logic                cs;
  fta_cmd_request64_t  req;
  fta_cmd_response64_t resp;
  logic [NLED-1:0]     led;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  ledport_pwm_fta64 #(.NLED(NLED), .PWM_DIV(1), .BLINK_RST(BRST)) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .req  (req),
    .resp (resp),
    .led  (led)
  );

  typedef struct {
    logic            we;
    fta_cycle_type_t cti;
    logic [31:0]     adr;
    logic [63:0]     dat;
    logic            exp_ack;
    logic            exp_err;
    logic [63:0]     exp_dat;
    logic [63:0]     mask;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Present one cs cycle; returns at the negedge where the registered response is visible.
  task automatic access(input logic we, input fta_cycle_type_t cti,
                        input logic [31:0] adr, input logic [63:0] dat);
    @(negedge clk);
    cs       = 1'b1;
    req      = '0;
    req.cid  = 4'h5;
    req.tid  = 13'h1A3;
    req.we   = we;
    req.cti  = cti;
    req.padr = adr;
    req.dat  = dat;
    @(negedge clk);
    cs     = 1'b0;
    req.we = 1'b0;
  endtask

  // Cycles between successive led[0] transitions, -1 if none within the bound.
  task automatic measure_toggle(output int n);
    logic prev;
    int   k;
    n = -1;
    @(negedge clk);
    prev = led[0];
    k = 0;
    while (led[0] == prev && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) return;
    prev = led[0];
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (led[0] != prev) begin n = k; return; end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi;

    vt[0]  = '{1'b0, CLASSIC, 32'h18, 64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, '1};
    vt[1]  = '{1'b0, CLASSIC, 32'h00, 64'h0, 1'b1, 1'b0, 64'h0, '1};
    vt[2]  = '{1'b0, CLASSIC, 32'h08, 64'h0, 1'b1, 1'b0, 64'h0, '1};
    vt[3]  = '{1'b0, CLASSIC, 32'h10, 64'h0, 1'b1, 1'b0, 64'd20, '1};
    vt[4]  = '{1'b0, CLASSIC, 32'h30, 64'h0, 1'b1, 1'b1, 64'h0, '1};
    vt[5]  = '{1'b1, ERC,     32'h08, 64'h1234_5678_9ABC_DE5A, 1'b1, 1'b0, 64'h0, '1};
    vt[6]  = '{1'b0, CLASSIC, 32'h08, 64'h0, 1'b1, 1'b0, 64'h5A, '1};
    vt[7]  = '{1'b1, CLASSIC, 32'h08, 64'h0, 1'b0, 1'b0, 64'h0, '1};
    vt[8]  = '{1'b0, CLASSIC, 32'h0F, 64'h0, 1'b1, 1'b0, 64'h0, '1};
    vt[9]  = '{1'b1, ERC,     32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0, '1};
    vt[10] = '{1'b0, CLASSIC, 32'h20, 64'h0, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_00FE};
    vt[11] = '{1'b1, ERC,     32'h28, 64'h55, 1'b1, 1'b1, 64'h0, '1};
    vt[12] = '{1'b0, CLASSIC, 32'hABCD_0017, 64'h0, 1'b1, 1'b0, 64'd20, '1};
    vt[13] = '{1'b1, ERC,     32'h18, 64'h0102_0304_0506_0740, 1'b1, 1'b0, 64'h0, '1};
    vt[14] = '{1'b0, CLASSIC, 32'h18, 64'h0, 1'b1, 1'b0, 64'h0102_0304_0506_0740, '1};
    vt[15] = '{1'b0, CLASSIC, 32'h38, 64'h0, 1'b1, 1'b1, 64'h0, '1};
    vt[16] = '{1'b1, ERC,     32'h00, 64'hFF00, 1'b1, 1'b0, 64'h0, '1};
    vt[17] = '{1'b0, CLASSIC, 32'h00, 64'h0, 1'b1, 1'b0, 64'h0, '1};

    rst = 1'b0;
    cs  = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 64'(resp.ack), 64'd0);
    chk("reset_led", 64'(led), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_no_ack", 64'(resp.ack), 64'd0);

    for (int i = 0; i < NV; i++) begin
      access(vt[i].we, vt[i].cti, vt[i].adr, vt[i].dat);
      chk($sformatf("v%0d_ack", i), 64'(resp.ack), 64'(vt[i].exp_ack));
      chk($sformatf("v%0d_err", i), 64'(resp.err), 64'(vt[i].exp_err));
      chk($sformatf("v%0d_dat", i), resp.dat & vt[i].mask, vt[i].exp_dat);
      chk($sformatf("v%0d_adr", i), 64'(resp.adr), 64'(vt[i].adr));
      chk($sformatf("v%0d_pri", i), 64'({resp.pri, resp.rty}), 64'h0E);
      @(negedge clk);
      chk($sformatf("v%0d_one_cycle", i), {63'd0, resp.ack} | resp.dat, 64'd0);
    end

    // Steady channel 0 at full brightness, enable written without ERC.
    access(1'b1, ERC, 32'h18, 64'hFFFF_FFFF_FFFF_FFFF);
    access(1'b1, CLASSIC, 32'h00, 64'h01);
    chk("leden_noack", 64'(resp.ack), 64'd0);
    @(negedge clk);
    chk("leden_led", 64'(led), 64'h01);

    // Duty 0x40 with one clock per step: 64 lit of every 256.
    access(1'b1, ERC, 32'h18, 64'hFFFF_FFFF_FFFF_FF40);
    repeat (3) @(negedge clk);
    hi = 0;
    for (int c = 0; c < 512; c++) begin
      @(negedge clk);
      if (led[0]) hi++;
      if (led[7:1] != 7'd0) hi += 1000;
    end
    chk("pwm_duty_hi", 64'(hi), 64'd128);

    // Blink at half-period 10, then 0 (toggle every cycle).
    access(1'b1, ERC, 32'h18, 64'hFFFF_FFFF_FFFF_FFFF);
    access(1'b1, ERC, 32'h10, 64'd10);
    access(1'b1, ERC, 32'h08, 64'h01);
    measure_toggle(n);
    chk("blink10_a", 64'(n), 64'd10);
    measure_toggle(n);
    chk("blink10_b", 64'(n), 64'd10);
    access(1'b1, ERC, 32'h10, 64'd0);
    measure_toggle(n);
    chk("blink0_a", 64'(n), 64'd1);
    measure_toggle(n);
    chk("blink0_b", 64'(n), 64'd1);

    // Reset arrives while a read is waiting for its capture edge.
    @(negedge clk);
    cs       = 1'b1;
    req.we   = 1'b0;
    req.padr = 32'h00;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_ack", 64'(resp.ack), 64'd0);
    chk("rst_led", 64'(led), 64'd0);
    cs  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ack", 64'(resp.ack), 64'd0);
    access(1'b0, CLASSIC, 32'h00, 64'h0);
    chk("rst_leden", resp.dat, 64'd0);
    access(1'b0, CLASSIC, 32'h08, 64'h0);
    chk("rst_mode", resp.dat, 64'd0);
    access(1'b0, CLASSIC, 32'h10, 64'h0);
    chk("rst_blink", resp.dat, 64'(BRST));
    access(1'b0, CLASSIC, 32'h18, 64'h0);
    chk("rst_bright", resp.dat, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
